// File: rtl/ad1939_pkg.sv
// rtl/ad1939_pkg.sv - shared types and defaults for the AD1939 ADC I2S receiver
package ad1939_pkg;

   typedef enum logic [1:0] {SYNC, SHIFT, WAIT} rx_state_t;

   localparam int AD1939_BITS_PER_CH_DEF = 32;
   localparam int AD1939_DATA_W_DEF      = 24;

   typedef struct packed {
      logic        channel;
      logic [23:0] data;
   } rx_sample_t;

endpackage

// File: rtl/ad1939_sync_edge.sv
// rtl/ad1939_sync_edge.sv - 2-FF synchronizer plus history FF with rise/fall pulses
module ad1939_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;
   logic hist;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         hist   <= 1'b0;
      end else begin
         meta   <= din;
         sync_q <= meta;
         hist   <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~hist;
   assign fall  = ~sync_q & hist;

endmodule

// File: rtl/ad1939_adc_i2s_rx.sv
// rtl/ad1939_adc_i2s_rx.sv - AD1939 ADC I2S deserializer to Avalon-ST samples
// Optional error counter port err_count enabled by AD1939_RX_ERRCNT_EN.
module ad1939_adc_i2s_rx
   import ad1939_pkg::*;
#(
   parameter int DATA_W      = AD1939_DATA_W_DEF,
   parameter int BITS_PER_CH = AD1939_BITS_PER_CH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ad1939_abclk,
   input  logic              ad1939_alrclk,
   input  logic              ad1939_asdata,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_channel,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              overrun,
   output logic              frame_err,
`ifdef AD1939_RX_ERRCNT_EN
   output logic [15:0]       err_count,
`endif
   input  logic              status_clr
);

   localparam logic [6:0] FRAME_BITS = 7'(BITS_PER_CH);
   localparam logic [5:0] LAST_BIT   = 6'(DATA_W - 1);

   logic bclk_lvl, bclk_rise, bclk_fall;
   logic lr_lvl, lr_rise, lr_fall;
   logic sd_lvl, sd_rise, sd_fall;
   logic unused_edges;

   ad1939_sync_edge u_sync_bclk (
      .clk(clk), .reset(reset), .din(ad1939_abclk),
      .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall)
   );

   ad1939_sync_edge u_sync_lrclk (
      .clk(clk), .reset(reset), .din(ad1939_alrclk),
      .level(lr_lvl), .rise(lr_rise), .fall(lr_fall)
   );

   ad1939_sync_edge u_sync_data (
      .clk(clk), .reset(reset), .din(ad1939_asdata),
      .level(sd_lvl), .rise(sd_rise), .fall(sd_fall)
   );

   assign unused_edges = ^{bclk_lvl, bclk_fall, lr_rise, lr_fall, sd_rise, sd_fall};

   rx_state_t         state;
   logic              lr_last;
   logic              primed;
   logic [5:0]        bit_cnt;
   logic [DATA_W-2:0] shreg;
   logic [DATA_W-1:0] word;
   logic              lr_edge;
   logic              len_bad;
   logic              err_now;
   logic              word_done;
   logic              xfer;

   // lr_last is meaningless until the first bclk_rise seeds it; without primed a
   // reset released during the right channel would fake an lr_edge.
   assign lr_edge   = bclk_rise & primed & (lr_lvl != lr_last);
   assign len_bad   = ({1'b0, bit_cnt} + 7'd1) != FRAME_BITS;
   assign err_now   = lr_edge & (state != SYNC) & ((state == SHIFT) | len_bad);
   assign word      = {shreg, sd_lvl};
   assign word_done = bclk_rise & ~lr_edge & (state == SHIFT) & (bit_cnt == LAST_BIT);
   assign xfer      = rx_valid & rx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lr_last <= 1'b0;
         primed  <= 1'b0;
         bit_cnt <= '0;
      end else if (bclk_rise) begin
         lr_last <= lr_lvl;
         primed  <= 1'b1;
         if (lr_edge)
            bit_cnt <= '0;
         else if (bit_cnt != 6'd63)
            bit_cnt <= bit_cnt + 6'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SYNC;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= err_now;
         case (state)
            SYNC: if (lr_edge) state <= SHIFT;
            SHIFT: begin
               // an lr_edge here restarts the word; the delay bit itself is never shifted
               if (lr_edge)
                  state <= SHIFT;
               else if (bclk_rise) begin
                  shreg <= word[DATA_W-2:0];
                  if (bit_cnt == LAST_BIT)
                     state <= WAIT;
               end
            end
            WAIT: if (lr_edge) state <= SHIFT;
            default: state <= SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data    <= '0;
         rx_channel <= 1'b0;
         rx_valid   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (word_done) begin
            rx_data    <= word;
            rx_channel <= lr_last;
            rx_valid   <= 1'b1;
         end else if (xfer) begin
            rx_valid <= 1'b0;
         end
         if (status_clr)
            overrun <= 1'b0;
         else if (word_done & rx_valid & ~rx_ready)
            overrun <= 1'b1;
      end
   end

`ifdef AD1939_RX_ERRCNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_count <= '0;
      else if (status_clr)
         err_count <= '0;
      else if (err_now && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ad1939_adc_i2s_rx.sv
// tb/tb_ad1939_adc_i2s_rx.sv - directed bench for ad1939_adc_i2s_rx with an I2S codec model
module tb_ad1939_adc_i2s_rx;
   import ad1939_pkg::*;

   localparam int HALF_BCLK = 164;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ad1939_abclk = 1'b0;
   logic        ad1939_alrclk = 1'b0;
   logic        ad1939_asdata = 1'b0;
   logic        rx_ready = 1'b1;
   logic        status_clr = 1'b0;
   logic [23:0] rx_data;
   logic        rx_channel;
   logic        rx_valid;
   logic        overrun;
   logic        frame_err;
`ifdef AD1939_RX_ERRCNT_EN
   logic [15:0] err_count;
`endif

   ad1939_adc_i2s_rx dut (
      .clk(clk),
      .reset(reset),
      .ad1939_abclk(ad1939_abclk),
      .ad1939_alrclk(ad1939_alrclk),
      .ad1939_asdata(ad1939_asdata),
      .rx_data(rx_data),
      .rx_channel(rx_channel),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .overrun(overrun),
      .frame_err(frame_err),
`ifdef AD1939_RX_ERRCNT_EN
      .err_count(err_count),
`endif
      .status_clr(status_clr)
   );

   // clk edges land on odd times, codec edges on even times, so they never coincide
   initial begin
      #5;
      forever #10 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   rx_sample_t got_q[$];
   int         ferr_cnt = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic       mark_lsb = 1'b0;
   event       lsb_ev;

   always @(negedge clk) begin
      rx_sample_t s;
      if (!reset && rx_valid && rx_ready) begin
         s.channel = rx_channel;
         s.data    = rx_data;
         got_q.push_back(s);
      end
      if (!reset && frame_err)
         ferr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_bits(input logic lr, input logic [23:0] w, input int first, input int last);
      logic [23:0] tmp;
      if ($time % 2 != 0) #1;
      for (int i = first; i < last; i++) begin
         ad1939_abclk  = 1'b0;
         ad1939_alrclk = lr;
         ad1939_asdata = 1'b0;
         if (i >= 1 && i <= 24) begin
            tmp = w >> (24 - i);
            ad1939_asdata = tmp[0];
         end
         #HALF_BCLK;
         ad1939_abclk = 1'b1;
         if (mark_lsb && i == 24) -> lsb_ev;
         #HALF_BCLK;
      end
   endtask

   task automatic send_half(input logic lr, input logic [23:0] w, input int n);
      send_bits(lr, w, 0, n);
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
      send_half(1'b0, l, 32);
      send_half(1'b1, r, 32);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #2 rx_ready = v;
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int idx;
      logic [23:0] exp_w;

      repeat (4) @(negedge clk);
      check("rst_data", rx_data, 0);
      check("rst_channel", rx_channel, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_err", frame_err, 0);
`ifdef AD1939_RX_ERRCNT_EN
      check("rst_err_count", err_count, 0);
`endif
      @(posedge clk);
      #2 reset = 1'b0;

      // basic L/R after a partial right half that must be skipped
      send_bits(1'b1, 24'h0, 0, 10);
      send_frame(24'h7FFFFF, 24'h800001);
      send_frame(24'h7FFFFF, 24'h800001);
      settle();
      check("t1_count", got_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check("t1_channel", got_q[k].channel, k % 2);
         check("t1_data", got_q[k].data, (k % 2) ? 24'h800001 : 24'h7FFFFF);
      end

      // reset mid-right channel
      got_q.delete();
      send_half(1'b0, 24'h111111, 32);
      send_bits(1'b1, 24'h222222, 0, 10);
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      got_q.delete();
      check("t2_rst_valid", rx_valid, 0);
      @(posedge clk);
      #2 reset = 1'b0;
      send_bits(1'b1, 24'h222222, 10, 32);
      send_frame(24'h123456, 24'h654321);
      settle();
      check("t2_count", got_q.size(), 2);
      check("t2_first_ch", got_q[0].channel, 0);
      check("t2_first_data", got_q[0].data, 24'h123456);
      check("t2_second_data", got_q[1].data, 24'h654321);
      check("t2_frame_err", ferr_cnt, 0);

      // overrun with rx_ready low for two words
      got_q.delete();
      set_ready(1'b0);
      send_frame(24'hA1A1A1, 24'hB2B2B2);
      settle();
      check("t3_valid", rx_valid, 1);
      check("t3_data", rx_data, 24'hB2B2B2);
      check("t3_channel", rx_channel, 1);
      check("t3_overrun", overrun, 1);
      check("t3_none_taken", got_q.size(), 0);
      @(posedge clk);
      #2 status_clr = 1'b1;
      @(posedge clk);
      #2 status_clr = 1'b0;
      @(negedge clk);
      check("t3_overrun_clr", overrun, 0);
      check("t3_valid_held", rx_valid, 1);
      set_ready(1'b1);
      settle();
      check("t3_drain_count", got_q.size(), 1);
      check("t3_drain_data", got_q[0].data, 24'hB2B2B2);
      check("t3_valid_after", rx_valid, 0);

      // 30-BCLK right half-frame
      got_q.delete();
      send_half(1'b0, 24'hC3C3C3, 32);
      send_half(1'b1, 24'hD4D4D4, 30);
      send_frame(24'hE5E5E5, 24'hF6F6F6);
      settle();
      check("t4_frame_err", ferr_cnt, 1);
      idx = got_q.size() - 2;
      if (idx < 0) idx = 0;
      check("t4_next_l", got_q[idx].data, 24'hE5E5E5);
      check("t4_next_l_ch", got_q[idx].channel, 0);
      check("t4_next_r", got_q[idx+1].data, 24'hF6F6F6);
`ifdef AD1939_RX_ERRCNT_EN
      check("t4_err_count", err_count, 1);
`endif

      // 12-BCLK half-frame: lr_edge lands mid-word, that word is dropped
      got_q.delete();
      send_half(1'b0, 24'h0A0A0A, 32);
      send_half(1'b1, 24'h0B0B0B, 12);
      send_frame(24'h0C0C0C, 24'h0D0D0D);
      settle();
      check("t4b_frame_err", ferr_cnt, 2);
      check("t4b_count", got_q.size(), 3);
      check("t4b_w0", got_q[0].data, 24'h0A0A0A);
      check("t4b_w1", got_q[1].data, 24'h0C0C0C);
      check("t4b_w1_ch", got_q[1].channel, 0);
      check("t4b_w2", got_q[2].data, 24'h0D0D0D);

      // rx_ready high exactly in the load cycle of the next word
      got_q.delete();
      set_ready(1'b0);
      fork
         begin
            send_half(1'b0, 24'h135790, 32);
            mark_lsb = 1'b1;
            send_half(1'b1, 24'h2468AC, 32);
            mark_lsb = 1'b0;
         end
         begin
            @(lsb_ev);
            @(posedge clk);
            @(posedge clk);
            #2 rx_ready = 1'b1;
            @(posedge clk);
            #2 rx_ready = 1'b0;
         end
      join
      settle();
      check("t5_taken", got_q.size(), 1);
      check("t5_old_data", got_q[0].data, 24'h135790);
      check("t5_valid", rx_valid, 1);
      check("t5_new_data", rx_data, 24'h2468AC);
      check("t5_new_ch", rx_channel, 1);
      check("t5_overrun", overrun, 0);
      set_ready(1'b1);
      settle();
      check("t5_drain", got_q[1].data, 24'h2468AC);

      // walking one across all 24 bit positions
      got_q.delete();
      for (int j = 0; j < 12; j++)
         send_frame(24'h1 << (23 - 2*j), 24'h1 << (22 - 2*j));
      settle();
      check("t6_count", got_q.size(), 24);
      for (int k = 0; k < 24; k++) begin
         exp_w = 24'h1 << (23 - k);
         check("t6_walk", got_q[k].data, exp_w);
         check("t6_walk_ch", got_q[k].channel, k % 2);
      end
      check("t6_frame_err", ferr_cnt, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
